// File: rtl/run_sequencer.sv
// run_sequencer: host-side initiator for the Start/Ack run handshake.
// Steps through programs, filters Ack, times each run, aborts on timeout.
module run_sequencer #(
  parameter int unsigned   NUM_PROGS    = 3,
  parameter int unsigned   START_CYCLES = 2,
  parameter int unsigned   CW           = 16,
  parameter logic [CW-1:0] TIMEOUT      = CW'(16'hFFFF)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          DutAck,
  output logic          DutStart,
  output logic [3:0]    ProgSel,
  output logic          Busy,
  output logic          RunValid,
  output logic [CW-1:0] RunCycles,
  output logic          Done,
  output logic          TimedOut
);

  localparam int PW =
    (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(START_CYCLES - 1);
  localparam logic [3:0] SEL_LAST =
    4'(NUM_PROGS - 1);
  localparam logic [CW-1:0] T_LAST =
    TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pcnt_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q;
  logic          golow_q;
  logic          start_q;
  logic [3:0]    sel_q;
  logic          busy_q;
  logic          valid_q;
  logic [CW-1:0] rcyc_q;
  logic          done_q;
  logic          tmo_q;

  logic confirm_d;
  logic tmo_hit_d;
  logic sel_last_d;
  logic pulse_end_d;

  // second consecutive high Ack sample inside RUN
  assign confirm_d   = ack_q & DutAck;
  assign tmo_hit_d   = (cnt_q == T_LAST);
  assign sel_last_d  = (sel_q == SEL_LAST);
  assign pulse_end_d = (pcnt_q == P_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      golow_q <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rcyc_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Go) begin
            state_q <= S_PULSE;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            sel_q   <= '0;
            pcnt_q  <= '0;
          end
        end
        S_PULSE: begin
          if (pulse_end_d) begin
            state_q <= S_RUN;
            start_q <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        S_RUN: begin
          ack_q <= DutAck;
          if (confirm_d) begin
            valid_q <= 1'b1;
            rcyc_q  <= cnt_q - 1'b1;
            if (sel_last_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              golow_q <= 1'b0;
            end else begin
              state_q <= S_GAP;
            end
          end else if (tmo_hit_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            golow_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q <= S_PULSE;
          sel_q   <= sel_q + 4'd1;
          start_q <= 1'b1;
          pcnt_q  <= '0;
        end
        S_DONE: begin
          // a held-high Go must drop once before it re-arms
          if (Go && golow_q) begin
            state_q <= S_PULSE;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            sel_q   <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
          end else if (!Go) begin
            golow_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DutStart  = start_q;
  assign ProgSel   = sel_q;
  assign Busy      = busy_q;
  assign RunValid  = valid_q;
  assign RunCycles = rcyc_q;
  assign Done      = done_q;
  assign TimedOut  = tmo_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: plans whole sequences as per-cycle expected traces,
// drives them with random Ack/Go, compares every cycle, pins key literals.
module tb_run_sequencer;

  localparam int NP = 3;
  localparam int SC = 2;
  localparam int CW = 16;
  localparam int T  = 20;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Go = 1'b0;
  logic          DutAck = 1'b0;
  logic          DutStart;
  logic [3:0]    ProgSel;
  logic          Busy;
  logic          RunValid;
  logic [CW-1:0] RunCycles;
  logic          Done;
  logic          TimedOut;

  run_sequencer #(
    .NUM_PROGS   (NP),
    .START_CYCLES(SC),
    .CW          (CW),
    .TIMEOUT     (16'(T))
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Go       (Go),
    .DutAck   (DutAck),
    .DutStart (DutStart),
    .ProgSel  (ProgSel),
    .Busy     (Busy),
    .RunValid (RunValid),
    .RunCycles(RunCycles),
    .Done     (Done),
    .TimedOut (TimedOut)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    bit        go;
    bit        ack;
    bit        start;
    bit [3:0]  sel;
    bit        busy;
    bit        valid;
    bit [15:0] rc;
    bit        done;
    bit        tmo;
  } cyc_t;

  typedef struct packed {
    bit [3:0]  sel;
    bit [15:0] rc;
  } strobe_t;

  cyc_t    plan[$];
  strobe_t strobes[$];
  int      widths[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int w      = 0;
  int start_rise = -1;
  int done_rise  = -1;
  bit prev_start = 1'b0;
  bit prev_done  = 1'b0;

  bit [3:0]  m_sel;
  bit [15:0] m_rc;
  bit        m_done;
  bit        m_tmo;
  bit        m_vnext;

  bit [NP-1:0][T-1:0] pats;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h",
                  nm, cyc, act, exp);
  endtask

  function automatic void push_rest(input bit go);
    cyc_t c;
    c       = '0;
    c.go    = go;
    c.ack   = 1'($urandom);
    c.sel   = m_sel;
    c.valid = m_vnext;
    c.rc    = m_rc;
    c.done  = m_done;
    c.tmo   = m_tmo;
    plan.push_back(c);
    m_vnext = 1'b0;
  endfunction

  // Whole sequence from a parked state: trigger, then per program
  // START_CYCLES pulse cycles, the run up to confirm/timeout, a gap.
  task automatic plan_seq(input bit [NP-1:0][T-1:0] a,
                          input bit stale);
    cyc_t c;
    int   conf;
    int   len;
    bit   stop;
    stop = 1'b0;
    push_rest(1'b1);
    m_done = 1'b0;
    m_tmo  = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (!stop) begin
        m_sel = 4'(p);
        for (int i = 0; i < SC; i++) begin
          c       = '0;
          c.go    = 1'($urandom);
          c.ack   = stale ? 1'b1 : 1'($urandom);
          c.start = 1'b1;
          c.sel   = m_sel;
          c.busy  = 1'b1;
          c.rc    = m_rc;
          plan.push_back(c);
        end
        conf = -1;
        for (int k = 1; k < T; k++)
          if (conf < 0 && a[p][k-1] && a[p][k]) conf = k;
        len = (conf >= 0) ? conf + 1 : T;
        for (int k = 0; k < len; k++) begin
          c      = '0;
          c.go   = 1'($urandom);
          c.ack  = a[p][k];
          c.sel  = m_sel;
          c.busy = 1'b1;
          c.rc   = m_rc;
          plan.push_back(c);
        end
        if (conf < 0) begin
          m_done = 1'b1;
          m_tmo  = 1'b1;
          stop   = 1'b1;
        end else begin
          m_rc = 16'(conf - 1);
          if (p == NP - 1) begin
            m_done  = 1'b1;
            m_vnext = 1'b1;
          end else begin
            c       = '0;
            c.go    = 1'($urandom);
            c.ack   = 1'($urandom);
            c.sel   = m_sel;
            c.busy  = 1'b1;
            c.valid = 1'b1;
            c.rc    = m_rc;
            plan.push_back(c);
          end
        end
      end
    end
  endtask

  task automatic done_tail(input int hi, input int lo);
    for (int i = 0; i < hi; i++) push_rest(1'b1);
    for (int i = 0; i < lo; i++) push_rest(1'b0);
  endtask

  task automatic compare(input cyc_t c);
    chk("DutStart",  32'(DutStart),  32'(c.start));
    chk("ProgSel",   32'(ProgSel),   32'(c.sel));
    chk("Busy",      32'(Busy),      32'(c.busy));
    chk("RunValid",  32'(RunValid),  32'(c.valid));
    chk("RunCycles", 32'(RunCycles), 32'(c.rc));
    chk("Done",      32'(Done),      32'(c.done));
    chk("TimedOut",  32'(TimedOut),  32'(c.tmo));
    if (RunValid === 1'b1) strobes.push_back({ProgSel, RunCycles});
    if (DutStart === 1'b1) w++;
    else if (w > 0) begin
      widths.push_back(w);
      w = 0;
    end
    if (DutStart === 1'b1 && !prev_start && start_rise < 0)
      start_rise = cyc;
    if (Done === 1'b1 && !prev_done && done_rise < 0)
      done_rise = cyc;
    prev_start = DutStart;
    prev_done  = Done;
    cyc++;
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge Clk);
      compare(c);
      Go     = c.go;
      DutAck = c.ack;
    end
  endtask

  task automatic clear_logs();
    strobes.delete();
    widths.delete();
    start_rise = -1;
    done_rise  = -1;
  endtask

  function automatic bit [T-1:0] rand_pat();
    bit [T-1:0] a;
    int m;
    a = '0;
    m = $urandom_range(7);
    if (m == 0) return a;
    if (m == 7) begin
      a[T-1] = 1'b1;
      a[T-2] = 1'b1;
      if ($urandom_range(1) == 1) a[T-4] = 1'b1;
      return a;
    end
    for (int k = 0; k < T; k++)
      a[k] = (m < 4) ? ($urandom_range(3) == 0)
                     : ($urandom_range(1) == 1);
    return a;
  endfunction

  initial begin
    m_sel = '0; m_rc = '0; m_done = 1'b0;
    m_tmo = 1'b0; m_vnext = 1'b0;

    // reset asserted in the middle of a start pulse
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    chk("pulse_before_reset", 32'(DutStart), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("rst_DutStart",  32'(DutStart),  32'd0);
    chk("rst_ProgSel",   32'(ProgSel),   32'd0);
    chk("rst_Busy",      32'(Busy),      32'd0);
    chk("rst_RunValid",  32'(RunValid),  32'd0);
    chk("rst_RunCycles", 32'(RunCycles), 32'd0);
    chk("rst_Done",      32'(Done),      32'd0);
    chk("rst_TimedOut",  32'(TimedOut),  32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) push_rest(1'b0);
    run_plan();

    // normal: Ack rises at counter 4 for every program
    clear_logs();
    for (int p = 0; p < NP; p++) pats[p] = 20'hFFFF0;
    plan_seq(pats, 1'b0);
    done_tail(3, 2);
    run_plan();
    chk("t2_strobe_count", 32'(strobes.size()), 32'd3);
    for (int i = 0; i < strobes.size(); i++) begin
      chk("t2_strobe_rc",  32'(strobes[i].rc),  32'd4);
      chk("t2_strobe_sel", 32'(strobes[i].sel), 32'(i));
    end
    chk("t2_pulse_count", 32'(widths.size()), 32'd3);
    for (int i = 0; i < widths.size(); i++)
      chk("t2_pulse_width", 32'(widths[i]), 32'd2);
    chk("t2_done", 32'(Done),     32'd1);
    chk("t2_tmo",  32'(TimedOut), 32'd0);

    // stale Ack through the pulse, glitch at 2, real rise at 9
    clear_logs();
    pats[0] = 20'hFFE04;
    pats[1] = 20'hFFFF0;
    pats[2] = 20'hFFFF0;
    plan_seq(pats, 1'b1);
    done_tail(0, 1);
    run_plan();
    chk("t3_strobe_count", 32'(strobes.size()), 32'd3);
    if (strobes.size() > 0) begin
      chk("t3_rc",  32'(strobes[0].rc),  32'd9);
      chk("t3_sel", 32'(strobes[0].sel), 32'd0);
    end

    // timeout on the first program, then Go held high in DONE
    clear_logs();
    pats = '0;
    plan_seq(pats, 1'b0);
    done_tail(5, 2);
    run_plan();
    chk("t4_no_strobe", 32'(strobes.size()), 32'd0);
    chk("t4_done",      32'(Done),           32'd1);
    chk("t4_tmo",       32'(TimedOut),       32'd1);
    chk("t4_sel",       32'(ProgSel),        32'd0);
    chk("t4_latency",   32'(done_rise - start_rise), 32'd22);

    // confirmation exactly on the last allowed counter value
    clear_logs();
    pats[0] = 20'hC0000;
    pats[1] = 20'hFFFF0;
    pats[2] = 20'hFFFF0;
    plan_seq(pats, 1'b0);
    done_tail(2, 1);
    run_plan();
    chk("t5_strobe_count", 32'(strobes.size()), 32'd3);
    if (strobes.size() > 0)
      chk("t5_rc", 32'(strobes[0].rc), 32'd18);
    chk("t5_tmo",  32'(TimedOut), 32'd0);
    chk("t5_done", 32'(Done),     32'd1);

    for (int s = 0; s < 30; s++) begin
      for (int p = 0; p < NP; p++) pats[p] = rand_pat();
      plan_seq(pats, 1'($urandom));
      done_tail($urandom_range(3), 1 + $urandom_range(2));
      run_plan();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
